// File: rtl/breath_pkg.sv
// rtl/breath_pkg.sv - shared encodings for the breath LED sequencer
// Purpose: mode and state encodings plus the default PWM width.
// Ports: none (package).
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BREATH = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int PWM_BITS_DEF = 8;

endpackage

// File: rtl/breath_pwm_gen.sv
// rtl/breath_pwm_gen.sv - free-running PWM with saturating duty compare
// Purpose: turns a 32-bit level into a single registered PWM bit.
// Ports:
//   CLK, NRST   clock, asynchronous active-low reset
//   cmp_en_i    1 = output follows the duty compare, 0 = output follows level_i
//   level_i     static output level used when the compare is disabled
//   val_i       32-bit ramp value; saturates at 2^PWM_BITS-1
//   pwm_o       registered PWM output
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        cmp_en_i,
  input  logic        level_i,
  input  logic [31:0] val_i,
  output logic        pwm_o
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_q;

  // Any bit above the PWM range means the value is out of range: saturate.
  always_comb begin
    duty = val_i[PWM_BITS-1:0];
    if (|(val_i >> PWM_BITS)) duty = DUTY_MAX;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= cmp_en_i ? (cnt_q < duty) : level_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/breath_sequencer.sv
// rtl/breath_sequencer.sv - mode sequencer and LED driver for the breath ramp
// Purpose: accepts mode commands, drains/reloads the breath instance and
//          drives the status LED in OFF/BREATH/SOLID/BLINK modes.
// Ports:
//   CLK, NRST                  clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY        command handshake
//   CMD_MODE/PERIOD/WAIT       command payload
//   BR_NRST, BR_PERIOD,
//   BR_WAIT_PERIOD, BR_OUT     breath instance control and ramp input
//   PWM_OUT                    LED drive
//   MODE, BUSY                 active mode, high while draining or loading
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int PWM_BITS      = PWM_BITS_DEF,
  parameter int RST_CYCLES    = 2,
  parameter int DRAIN_EN      = 1,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_MODE,
  input  logic [15:0] CMD_PERIOD,
  input  logic [15:0] CMD_WAIT,
  output logic        BR_NRST,
  output logic [31:0] BR_PERIOD,
  output logic [31:0] BR_WAIT_PERIOD,
  input  logic [31:0] BR_OUT,
  output logic        PWM_OUT,
  output logic [1:0]  MODE,
  output logic        BUSY
);

  localparam int          LOAD_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [LOAD_W-1:0] LOAD_LAST  = LOAD_W'(RST_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

  state_e              state_q;
  mode_e               mode_q;
  mode_e               pend_mode_q;
  logic [15:0]         pend_period_q;
  logic [15:0]         pend_wait_q;
  logic [31:0]         br_period_q;
  logic [31:0]         br_wait_q;
  logic [31:0]         drain_cnt_q;
  logic [LOAD_W-1:0]   load_cnt_q;
  logic [15:0]         blink_cnt_q;
  logic                blink_tgl_q;

  logic accept;
  logic pwm_cmp_en;
  logic pwm_level;

  assign CMD_READY = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign BUSY      = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
  assign accept    = CMD_VALID && CMD_READY;

  // The breath instance only runs while it is producing the LED level; any
  // other state keeps it in reset so a new ramp always starts from 0.
  assign BR_NRST = (state_q == ST_DRAIN) ||
                   ((state_q == ST_RUN) && (mode_q == MODE_BREATH));

  assign BR_PERIOD      = br_period_q;
  assign BR_WAIT_PERIOD = br_wait_q;
  assign MODE           = mode_q;

  assign pwm_cmp_en = BR_NRST;
  assign pwm_level  = (state_q == ST_RUN) &&
                      ((mode_q == MODE_SOLID) || ((mode_q == MODE_BLINK) && blink_tgl_q));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_OFF;
      pend_mode_q   <= MODE_OFF;
      pend_period_q <= '0;
      pend_wait_q   <= '0;
      br_period_q   <= '0;
      br_wait_q     <= '0;
      drain_cnt_q   <= '0;
      load_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_tgl_q   <= 1'b0;
    end else begin
      // Blink phase counter: flips the toggle after period+1 cycles.
      if ((state_q == ST_RUN) && (mode_q == MODE_BLINK)) begin
        if (blink_cnt_q == br_period_q[15:0]) begin
          blink_cnt_q <= '0;
          blink_tgl_q <= ~blink_tgl_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 16'd1;
        end
      end

      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            pend_mode_q   <= mode_e'(CMD_MODE);
            pend_period_q <= CMD_PERIOD;
            pend_wait_q   <= CMD_WAIT;
            if ((state_q == ST_RUN) && (mode_q == MODE_BREATH) && (DRAIN_EN != 0)) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= '0;
            end else begin
              state_q     <= ST_LOAD;
              load_cnt_q  <= '0;
              br_period_q <= {16'd0, CMD_PERIOD};
              br_wait_q   <= {16'd0, CMD_WAIT};
            end
          end
        end
        ST_DRAIN: begin
          if ((BR_OUT == 32'd0) || (drain_cnt_q == DRAIN_LAST)) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            br_period_q <= {16'd0, pend_period_q};
            br_wait_q   <= {16'd0, pend_wait_q};
          end else begin
            drain_cnt_q <= drain_cnt_q + 32'd1;
          end
        end
        ST_LOAD: begin
          if (load_cnt_q == LOAD_LAST) begin
            mode_q      <= pend_mode_q;
            state_q     <= (pend_mode_q == MODE_OFF) ? ST_IDLE : ST_RUN;
            blink_cnt_q <= '0;
            blink_tgl_q <= 1'b1;
          end else begin
            load_cnt_q <= load_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .CLK      (CLK),
    .NRST     (NRST),
    .cmp_en_i (pwm_cmp_en),
    .level_i  (pwm_level),
    .val_i    (BR_OUT),
    .pwm_o    (PWM_OUT)
  );

endmodule
